sine_phase_sequencer: RTL
=========================

// Module: sine_phase_sequencer
// PURPOSE
// Downstream consumer of the prescaler tick (clk_div). On each tick rising edge it
// advances a phase accumulator by a frequency control word, looks up a quarter-wave
// sine ROM with symmetry folding, and presents one signed sample to the DAC/output
// stage over a valid/ready handshake. It sets the sample-rate-to-frequency relation.
// PARAMETERS
// PHASE_W  16  phase accumulator width; top 2 bits = quadrant
// ADDR_W   8   quarter-wave ROM address width (2**ADDR_W entries); ADDR_W <= PHASE_W-2
// DATA_W   12  signed output sample width; ROM stores DATA_W-1 bit unsigned magnitude
// PORTS
// src_clk       in   1        single system clock; all logic on posedge
// rst_n         in   1        synchronous reset, active-low
// en            in   1        0: ticks ignored, phase frozen; FSM still drains
// tick          in   1        prescaler clk_div; rising edge = sample request
// fcw           in   PHASE_W  frequency control word; sampled on accepted tick
// sample        out  DATA_W   signed sine sample
// sample_valid  out  1        sample holds a new value
// sample_ready  in   1        downstream accepts sample when valid&ready
// overrun_cnt   out  8        saturating count of ticks dropped while busy
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): phase=0, tick_d=0, state=IDLE, sample=0,
//   sample_valid=0, overrun_cnt=0. Reset wins over every other event.
// - Edge detect: tick_d <= tick; edge = tick & ~tick_d. Held-high tick = one edge.
// - Accepted tick = edge & en. On every accepted tick: phase <= phase + fcw
//   (mod 2**PHASE_W, wraps silently), regardless of FSM state.
// - FSM: IDLE -> FETCH -> WAIT -> PRESENT -> IDLE.
//   IDLE: on accepted tick latch q=phase[PHASE_W-1 -: 2] and
//     idx=phase[PHASE_W-3 -: ADDR_W] from PRE-increment phase; rom_addr = idx for
//     q=0,2, ~idx for q=1,3; neg = q[1]; go FETCH.
//   FETCH: ROM (1-cycle sync read) reads rom_addr; go WAIT.
//   WAIT: sample <= neg ? -{1'b0,mag} : {1'b0,mag}; sample_valid <= 1; go PRESENT.
//   PRESENT: hold sample/valid stable until valid&ready; on handshake valid <= 0,
//     go IDLE (new fetch can start on the following cycle's edge).
// - Latency: edge at cycle N (IDLE) -> sample_valid=1 at N+3.
// - Accepted tick while state != IDLE: phase still advances, no fetch launched,
//   overrun_cnt increments, saturating at 255. Held sample not modified.
// - Tick in same cycle as PRESENT handshake: counted as overrun (state not IDLE).
// - en=0: no phase update, no fetch, no overrun count; in-flight fetch completes.
// - No overflow on negation: |mag| <= 2**(DATA_W-1)-1.
// - fcw changes take effect on next accepted tick only.
// STRUCTURE
// - PHASE_W/ADDR_W/DATA_W defaults and state encodings (IDLE=0,FETCH=1,WAIT=2,
//   PRESENT=3) as macros in ../config.v next to SOURCE_CLK/Output_frequency.
// - Sub-module sine_quarter_rom #(ADDR_W,DATA_W-1): src_clk, addr -> mag, registered
//   read, contents from $readmemh file; mag = round((2**(DATA_W-1)-1)*sin((a+0.5)*pi/2/2**ADDR_W)).
// - Top holds edge detect, accumulator, FSM, fold/negate, overrun counter.
// TESTING (PHASE_W=16, ADDR_W=8, DATA_W=12, sample_ready=1 unless stated)
// 1 rst_n=0 two cycles mid-run -> sample=0, sample_valid=0, overrun_cnt=0, next
//   tick yields sample for phase 0 (= +rom[0]).
// 2 fcw=0x4000, four ticks 20 cycles apart -> samples +rom[0], +rom[255],
//   -rom[0], -rom[255]; fifth tick back to +rom[0] (wrap).
// 3 single tick edge at cycle N -> sample_valid high exactly at N+3 for 1 cycle.
// 4 sample_ready=0, second tick at N+5 -> sample/valid unchanged, overrun_cnt=1;
//   300 such ticks -> overrun_cnt=255; phase advanced on every tick.
// 5 tick held high 10 cycles -> exactly one sample_valid pulse, phase += fcw once.
// 6 en=0 with ticks -> no valid, phase constant; en=1 -> resumes from held phase.

Source files
------------

// File: rtl/sine_phase_sequencer_pkg.sv
// rtl/sine_phase_sequencer_pkg.sv - shared types and ROM table generator for the sine sequencer
package sine_phase_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_PRESENT = 2'd3
    } seq_state_t;

    // Magnitude of the quarter-wave entry a, sampled at bin centres so the fold is symmetric.
    // Evaluated at elaboration only; the Taylor series is exact to well below one LSB on [0, pi/2].
    function automatic int quarter_sine_mag(input int a, input int addr_w, input int mag_w);
        real x;
        real x2;
        real term;
        real s;
        x    = (real'(a) + 0.5) * 3.14159265358979323846 / (2.0 * real'(1 << addr_w));
        x2   = x * x;
        term = x;
        s    = x;
        for (int k = 1; k <= 12; k++) begin
            term = -term * x2 / real'((2 * k) * (2 * k + 1));
            s    = s + term;
        end
        return $rtoi(s * real'((1 << mag_w) - 1) + 0.5);
    endfunction

endpackage

// File: rtl/sine_phase_sequencer_rom.sv
// rtl/sine_phase_sequencer_rom.sv - quarter-wave sine magnitude ROM with registered read
module sine_quarter_rom
    import sine_phase_sequencer_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int MAG_W  = 11
) (
    input  logic              src_clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [MAG_W-1:0]  mag
);

    logic [MAG_W-1:0] rom_tbl [2**ADDR_W];

    for (genvar i = 0; i < 2**ADDR_W; i++) begin : g_tbl
        localparam int ENTRY = quarter_sine_mag(i, ADDR_W, MAG_W);
        assign rom_tbl[i] = ENTRY[MAG_W-1:0];
    end

    always_ff @(posedge src_clk) begin
        mag <= rom_tbl[addr];
    end

endmodule

// File: rtl/sine_phase_sequencer.sv
// rtl/sine_phase_sequencer.sv - tick-driven phase accumulator feeding a folded sine ROM to a valid/ready sink
module sine_phase_sequencer
    import sine_phase_sequencer_pkg::*;
#(
    parameter int PHASE_W = 16,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 12
) (
    input  logic               src_clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               tick,
    input  logic [PHASE_W-1:0] fcw,
    output logic [DATA_W-1:0]  sample,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic [7:0]         overrun_cnt
);

    seq_state_t          state;
    seq_state_t          state_nx;
    logic                tick_d;
    logic                tick_acc;
    logic [PHASE_W-1:0]  phase;
    logic [1:0]          quad;
    logic [ADDR_W-1:0]   idx;
    logic [ADDR_W-1:0]   rom_addr;
    logic                neg;
    logic [DATA_W-2:0]   mag;
    logic [DATA_W-1:0]   mag_ext;

    assign tick_acc = tick & ~tick_d & en;
    assign quad     = phase[PHASE_W-1 -: 2];
    assign idx      = phase[PHASE_W-3 -: ADDR_W];
    assign mag_ext  = {1'b0, mag};

    sine_quarter_rom #(
        .ADDR_W (ADDR_W),
        .MAG_W  (DATA_W - 1)
    ) u_rom (
        .src_clk (src_clk),
        .addr    (rom_addr),
        .mag     (mag)
    );

    always_ff @(posedge src_clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (tick_acc) state_nx = ST_FETCH;
            ST_FETCH:   state_nx = ST_WAIT;
            ST_WAIT:    state_nx = ST_PRESENT;
            ST_PRESENT: if (sample_ready) state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Address and sign are taken from the phase before this tick's increment.
    always_ff @(posedge src_clk) begin
        if (!rst_n) begin
            tick_d       <= 1'b0;
            phase        <= '0;
            rom_addr     <= '0;
            neg          <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun_cnt  <= '0;
        end else begin
            tick_d <= tick;
            if (tick_acc) begin
                phase <= phase + fcw;
            end
            if (state == ST_IDLE && tick_acc) begin
                rom_addr <= quad[0] ? ~idx : idx;
                neg      <= quad[1];
            end
            if (state == ST_WAIT) begin
                sample       <= neg ? -mag_ext : mag_ext;
                sample_valid <= 1'b1;
            end
            if (state == ST_PRESENT && sample_ready) begin
                sample_valid <= 1'b0;
            end
            if (tick_acc && state != ST_IDLE && overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end
    end

endmodule
